// File: rtl/sp_wait_bridge_if.sv
// SP bus bundle between DMAC and the wait-state bridge, including the slow-memory side.
// slave is the bridge's view; master is the DMAC and memory environment.
interface sp_wait_bridge_if #(
   parameter int ADR_SIZE  = 16,
   parameter int DATA_SIZE = 16
);
   logic                 sp_en;
   logic                 wr_rd_sp;
   logic [ADR_SIZE-1:0]  SPA;
   logic [DATA_SIZE-1:0] SPD_OUT;
   logic [DATA_SIZE-1:0] SPD_IN;
   logic                 stall_ext;
   logic                 mem_en;
   logic                 mem_wr;
   logic [ADR_SIZE-1:0]  mem_adr;
   logic [DATA_SIZE-1:0] mem_wdata;
   logic [DATA_SIZE-1:0] mem_rdata;

   modport slave (
      input  sp_en, wr_rd_sp, SPA, SPD_OUT, mem_rdata,
      output SPD_IN, stall_ext, mem_en, mem_wr, mem_adr, mem_wdata
   );

   modport master (
      output sp_en, wr_rd_sp, SPA, SPD_OUT, mem_rdata,
      input  SPD_IN, stall_ext, mem_en, mem_wr, mem_adr, mem_wdata
   );
endinterface

// File: rtl/sp_wait_bridge.sv
// Slave-side SP bridge: posts DMAC writes into a FIFO, drains them to slow memory with fixed wait states,
// and runs reads in order behind them. Define SP_BRIDGE_STATS_EN to add wr_posted_cnt/stall_cnt outputs.
module sp_wait_bridge #(
   parameter int ADR_SIZE    = 16,
   parameter int DATA_SIZE   = 16,
   parameter int WAIT_CYCLES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic            clk,
   input  logic            rst,
   sp_wait_bridge_if.slave bus
`ifdef SP_BRIDGE_STATS_EN
   ,
   output logic [15:0]     wr_posted_cnt,
   output logic [15:0]     stall_cnt
`endif
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int ENT_W = ADR_SIZE + DATA_SIZE;
   localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WR, RD, RD_DONE} state_e;

   state_e               state_q, state_d;
   logic [ENT_W-1:0]     fifoMem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wrPtr_q, rdPtr_q;
   logic [PTR_W:0]       count_q, count_d;
   logic [CNT_W-1:0]     waitCnt_q, waitCnt_d;
   logic                 memEn_q, memEn_d;
   logic                 memWr_q, memWr_d;
   logic [ADR_SIZE-1:0]  memAdr_q, memAdr_d;
   logic [DATA_SIZE-1:0] memWdata_q, memWdata_d;
   logic [DATA_SIZE-1:0] spdIn_q, spdIn_d;
   logic                 fifoFull, fifoEmpty, push, pop, startRd, stall;
   logic [ENT_W-1:0]     head;

   assign fifoFull  = (count_q == FULL_CNT);
   assign fifoEmpty = (count_q == '0);
   assign head      = fifoMem_q[rdPtr_q];
   assign push      = bus.sp_en & bus.wr_rd_sp & ~fifoFull;

   // A read only gets through in RD_DONE, so it stalls behind every posted write and its own access.
   assign stall = ~rst & bus.sp_en &
                  ((bus.wr_rd_sp & fifoFull) | (~bus.wr_rd_sp & (state_q != RD_DONE)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         waitCnt_q  <= '0;
         memEn_q    <= 1'b0;
         memWr_q    <= 1'b0;
         memAdr_q   <= '0;
         memWdata_q <= '0;
         spdIn_q    <= '0;
      end else begin
         state_q    <= state_d;
         wrPtr_q    <= push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
         rdPtr_q    <= pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
         count_q    <= count_d;
         waitCnt_q  <= waitCnt_d;
         memEn_q    <= memEn_d;
         memWr_q    <= memWr_d;
         memAdr_q   <= memAdr_d;
         memWdata_q <= memWdata_d;
         spdIn_q    <= spdIn_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifoMem_q[wrPtr_q] <= {bus.SPA, bus.SPD_OUT};
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Posted writes win over a pending read, which keeps reads ordered behind earlier writes.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      startRd = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifoEmpty) begin
               pop     = 1'b1;
               state_d = WR;
            end else if (bus.sp_en && !bus.wr_rd_sp) begin
               startRd = 1'b1;
               state_d = RD;
            end
         end
         WR: begin
            if (waitCnt_q == '0) begin
               if (!fifoEmpty) pop = 1'b1;
               else            state_d = IDLE;
            end
         end
         RD:      if (waitCnt_q == '0) state_d = RD_DONE;
         RD_DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      memEn_d    = memEn_q;
      memWr_d    = memWr_q;
      memAdr_d   = memAdr_q;
      memWdata_d = memWdata_q;
      waitCnt_d  = waitCnt_q;
      spdIn_d    = spdIn_q;
      if (pop) begin
         memEn_d    = 1'b1;
         memWr_d    = 1'b1;
         memAdr_d   = head[ENT_W-1:DATA_SIZE];
         memWdata_d = head[DATA_SIZE-1:0];
         waitCnt_d  = WAIT_LOAD;
      end else if (startRd) begin
         memEn_d   = 1'b1;
         memWr_d   = 1'b0;
         memAdr_d  = bus.SPA;
         waitCnt_d = WAIT_LOAD;
      end else if ((state_q == WR || state_q == RD) && waitCnt_q != '0) begin
         waitCnt_d = waitCnt_q - CNT_W'(1);
      end else if (state_q == WR) begin
         memEn_d = 1'b0;
      end else if (state_q == RD) begin
         memEn_d = 1'b0;
         spdIn_d = bus.mem_rdata;
      end
   end

   assign bus.stall_ext = stall;
   assign bus.mem_en    = memEn_q;
   assign bus.mem_wr    = memWr_q;
   assign bus.mem_adr   = memAdr_q;
   assign bus.mem_wdata = memWdata_q;
   assign bus.SPD_IN    = spdIn_q;

`ifdef SP_BRIDGE_STATS_EN
   logic [15:0] wrPostedCnt_q, stallCnt_q;

   // Saturating statistics; they never wrap so a long run cannot report a small count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPostedCnt_q <= '0;
         stallCnt_q    <= '0;
      end else begin
         if (push && wrPostedCnt_q != 16'hFFFF) wrPostedCnt_q <= wrPostedCnt_q + 16'd1;
         if (stall && stallCnt_q != 16'hFFFF)   stallCnt_q    <= stallCnt_q + 16'd1;
      end
   end

   assign wr_posted_cnt = wrPostedCnt_q;
   assign stall_cnt     = stallCnt_q;
`endif
endmodule

// File: tb/tb_sp_wait_bridge.sv
// Self-checking bench for sp_wait_bridge: directed scenarios plus a randomized run checked against
// a DMAC-view memory model and the expected order of memory-bus accesses.
module tb_sp_wait_bridge;
   localparam int AW      = 16;
   localparam int DW      = 16;
   localparam int W       = 2;
   localparam int D       = 4;
   localparam int ACC_LEN = W + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sp_wait_bridge_if #(.ADR_SIZE(AW), .DATA_SIZE(DW)) bus();

`ifdef SP_BRIDGE_STATS_EN
   logic [15:0] wrPostedCnt, stallCnt;
`endif

   sp_wait_bridge #(.ADR_SIZE(AW), .DATA_SIZE(DW), .WAIT_CYCLES(W), .FIFO_DEPTH(D)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef SP_BRIDGE_STATS_EN
      ,
      .wr_posted_cnt(wrPostedCnt),
      .stall_cnt(stallCnt)
`endif
   );

   // Contents of a location nobody has written yet; 0x20 holds the value the read scenario expects.
   function automatic logic [15:0] initVal(input logic [7:0] a);
      if (a == 8'h20) return 16'h1234;
      return {a, ~a} ^ 16'h0F0F;
   endfunction

   // Slow external memory: stores whatever the bridge writes, returns data for the current address.
   logic [15:0] extMem [256];
   bit          extValid [256];
   assign bus.mem_rdata = extValid[bus.mem_adr[7:0]] ? extMem[bus.mem_adr[7:0]] : initVal(bus.mem_adr[7:0]);

   always @(negedge clk) begin
      if (bus.mem_en === 1'b1 && bus.mem_wr === 1'b1) begin
         extMem[bus.mem_adr[7:0]]   <= bus.mem_wdata;
         extValid[bus.mem_adr[7:0]] <= 1'b1;
      end
   end

   // Memory contents as DMAC should see them: every accepted write takes effect immediately.
   logic [15:0] goldMem [256];
   bit          goldValid [256];

   typedef struct { logic wr; logic [15:0] adr; logic [15:0] data; int start; int len; } acc_t;
   typedef struct { logic wr; logic [15:0] adr; logic [15:0] data; } exp_t;
   acc_t accLog[$];
   exp_t expQ[$];
   logic prevEn = 1'b0;

   // Bus monitor: splits mem_en activity into accesses of at most ACC_LEN cycles each.
   always @(negedge clk) begin
      acc_t t;
      if (bus.mem_en === 1'b1) begin
         if (prevEn !== 1'b1 || accLog.size() == 0 || accLog[accLog.size()-1].wr !== bus.mem_wr ||
             accLog[accLog.size()-1].adr !== bus.mem_adr ||
             (bus.mem_wr === 1'b1 && accLog[accLog.size()-1].data !== bus.mem_wdata) ||
             accLog[accLog.size()-1].len >= ACC_LEN) begin
            t.wr = bus.mem_wr; t.adr = bus.mem_adr; t.data = bus.mem_wdata; t.start = cyc; t.len = 1;
            accLog.push_back(t);
         end else begin
            t = accLog.pop_back();
            t.len = t.len + 1;
            accLog.push_back(t);
         end
      end
      prevEn = bus.mem_en;
   end

   task automatic dmacWrite(input logic [15:0] a, input logic [15:0] d, output int stalls, output int accCyc);
      exp_t e;
      bit   ok = 1'b0;
      bus.sp_en = 1'b1; bus.wr_rd_sp = 1'b1; bus.SPA = a; bus.SPD_OUT = d;
      stalls = 0; accCyc = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.stall_ext === 1'b0) begin ok = 1'b1; accCyc = cyc; end
         else stalls++;
      end
      if (!ok) begin
         checks++; failures++;
         $display("[TB] FAIL write_accept_timeout: adr=%h still stalled after 200 cycles, expected acceptance", a);
      end else begin
         e.wr = 1'b1; e.adr = a; e.data = d;
         expQ.push_back(e);
         goldMem[a[7:0]] = d; goldValid[a[7:0]] = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic dmacRead(input logic [15:0] a, output logic [15:0] d, output int stalls, output int accCyc);
      exp_t e;
      bit   ok = 1'b0;
      bus.sp_en = 1'b1; bus.wr_rd_sp = 1'b0; bus.SPA = a;
      stalls = 0; accCyc = 0; d = 'x;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.stall_ext === 1'b0) begin ok = 1'b1; accCyc = cyc; d = bus.SPD_IN; end
         else stalls++;
      end
      if (!ok) begin
         checks++; failures++;
         $display("[TB] FAIL read_accept_timeout: adr=%h still stalled after 200 cycles, expected completion", a);
      end else begin
         e.wr = 1'b0; e.adr = a; e.data = '0;
         expQ.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   task automatic dmacIdle(input int n);
      bus.sp_en = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.sp_en = 1'b1; bus.wr_rd_sp = 1'b0; bus.SPA = 16'h0020; bus.SPD_OUT = 16'h0;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (bus.stall_ext !== 1'b0 || bus.mem_en !== 1'b0 || bus.SPD_IN !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got stall=%b mem_en=%b SPD_IN=%h, expected 0 0 0000",
                     bus.stall_ext, bus.mem_en, bus.SPD_IN);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0; bus.sp_en = 1'b0;
      accLog.delete(); expQ.delete();
      dmacIdle(8);
      checks++;
      if (accLog.size() !== 0 || bus.mem_en !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_fifo_empty: got %0d accesses mem_en=%b, expected 0 accesses mem_en=0",
                  accLog.size(), bus.mem_en);
      end
   endtask

   task automatic test_single_write();
      int st, c;
      accLog.delete(); expQ.delete();
      dmacWrite(16'h0010, 16'hABCD, st, c);
      dmacIdle(10);
      checks++;
      if (st !== 0) begin failures++; $display("[TB] FAIL single_write_stall: got %0d stall cycles, expected 0", st); end
      checks++;
      if (accLog.size() !== 1) begin
         failures++; $display("[TB] FAIL single_write_count: got %0d accesses, expected 1", accLog.size());
      end else begin
         checks++;
         if (accLog[0].wr !== 1'b1 || accLog[0].adr !== 16'h0010 || accLog[0].data !== 16'hABCD ||
             accLog[0].len !== ACC_LEN || accLog[0].start !== c + 2) begin
            failures++;
            $display("[TB] FAIL single_write_bus: got wr=%b adr=%h data=%h len=%0d start=%0d, expected 1 0010 abcd %0d %0d",
                     accLog[0].wr, accLog[0].adr, accLog[0].data, accLog[0].len, accLog[0].start, ACC_LEN, c + 2);
         end
      end
   endtask

   task automatic test_burst();
      int st, c, totalStalls;
      rst = 1'b1; bus.sp_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      accLog.delete(); expQ.delete();
      totalStalls = 0;
      for (int a = 1; a <= 8; a++) begin
         dmacWrite(16'(a), 16'hB000 | 16'(a), st, c);
         totalStalls += st;
      end
      dmacIdle(40);
      // With W=2 and a 4-deep FIFO the 7th and 8th writes each wait two cycles for a pop.
      checks++;
      if (totalStalls !== 4) begin failures++; $display("[TB] FAIL burst_stalls: got %0d, expected 4", totalStalls); end
      checks++;
      if (accLog.size() !== 8) begin
         failures++; $display("[TB] FAIL burst_count: got %0d accesses, expected 8", accLog.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (accLog[i].wr !== 1'b1 || accLog[i].adr !== expQ[i].adr || accLog[i].data !== expQ[i].data ||
                accLog[i].len !== ACC_LEN || accLog[i].start !== accLog[0].start + i * ACC_LEN) begin
               failures++;
               $display("[TB] FAIL burst_access%0d: got adr=%h data=%h len=%0d start=%0d, expected %h %h %0d %0d",
                        i, accLog[i].adr, accLog[i].data, accLog[i].len, accLog[i].start,
                        expQ[i].adr, expQ[i].data, ACC_LEN, accLog[0].start + i * ACC_LEN);
            end
         end
      end
`ifdef SP_BRIDGE_STATS_EN
      checks++;
      if (wrPostedCnt !== 16'd8 || stallCnt !== 16'(totalStalls)) begin
         failures++;
         $display("[TB] FAIL burst_stats: got wr_posted_cnt=%0d stall_cnt=%0d, expected 8 %0d",
                  wrPostedCnt, stallCnt, totalStalls);
      end
`endif
   endtask

   task automatic test_read();
      int st, c;
      logic [15:0] d;
      accLog.delete(); expQ.delete();
      dmacRead(16'h0020, d, st, c);
      dmacIdle(4);
      checks++;
      if (d !== 16'h1234 || st !== W + 2) begin
         failures++; $display("[TB] FAIL read_result: got data=%h stalls=%0d, expected 1234 %0d", d, st, W + 2);
      end
      checks++;
      if (accLog.size() !== 1 || accLog[0].wr !== 1'b0 || accLog[0].adr !== 16'h0020 ||
          accLog[0].len !== ACC_LEN || accLog[0].start !== c - st + 1) begin
         failures++;
         $display("[TB] FAIL read_bus: got %0d accesses (first wr=%b adr=%h len=%0d), expected 1 read of 0020 len %0d",
                  accLog.size(), accLog.size() > 0 ? accLog[0].wr : 1'bx, accLog.size() > 0 ? accLog[0].adr : 16'hx,
                  accLog.size() > 0 ? accLog[0].len : -1, ACC_LEN);
      end
      checks++;
      if (bus.SPD_IN !== 16'h1234) begin
         failures++; $display("[TB] FAIL read_hold: got SPD_IN=%h, expected 1234", bus.SPD_IN);
      end
   endtask

   task automatic test_raw();
      int st, c, cw;
      logic [15:0] d;
      accLog.delete(); expQ.delete();
      dmacWrite(16'h0030, 16'h5A5A, st, cw);
      dmacRead(16'h0030, d, st, c);
      dmacIdle(4);
      checks++;
      if (d !== 16'h5A5A || st !== 2 * W + 4) begin
         failures++; $display("[TB] FAIL raw_result: got data=%h stalls=%0d, expected 5a5a %0d", d, st, 2 * W + 4);
      end
      checks++;
      if (accLog.size() !== 2) begin
         failures++; $display("[TB] FAIL raw_count: got %0d accesses, expected 2", accLog.size());
      end else if (accLog[0].wr !== 1'b1 || accLog[1].wr !== 1'b0 || accLog[1].adr !== 16'h0030 ||
                   accLog[1].start !== accLog[0].start + W + 2) begin
         checks++; failures++;
         $display("[TB] FAIL raw_order: got wr0=%b wr1=%b adr1=%h gap=%0d, expected 1 0 0030 %0d",
                  accLog[0].wr, accLog[1].wr, accLog[1].adr, accLog[1].start - accLog[0].start, W + 2);
      end else begin
         checks++;
      end
   endtask

   task automatic test_reset_mid_read();
      int n, st, c;
      logic [15:0] d;
      bus.sp_en = 1'b1; bus.wr_rd_sp = 1'b0; bus.SPA = 16'h0040;
      @(posedge clk); #1;
      bus.wr_rd_sp = 1'b1; bus.SPA = 16'h0041; bus.SPD_OUT = 16'hDEAD;
      @(posedge clk); #1;
      bus.SPA = 16'h0042; bus.SPD_OUT = 16'hBEEF; rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.stall_ext !== 1'b0) begin failures++; $display("[TB] FAIL midreset_stall: got %b, expected 0", bus.stall_ext); end
      @(posedge clk); #1;
      rst = 1'b0; bus.sp_en = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.mem_en !== 1'b0 || bus.SPD_IN !== 16'h0) begin
         failures++; $display("[TB] FAIL midreset_outputs: got mem_en=%b SPD_IN=%h, expected 0 0000", bus.mem_en, bus.SPD_IN);
      end
      n = accLog.size();
      dmacIdle(12);
      checks++;
      if (accLog.size() !== n) begin
         failures++; $display("[TB] FAIL midreset_no_access: got %0d new accesses, expected 0", accLog.size() - n);
      end
      dmacRead(16'h0041, d, st, c);
      checks++;
      if (d !== initVal(8'h41) || st !== W + 2) begin
         failures++; $display("[TB] FAIL midreset_discard: got data=%h stalls=%0d, expected %h %0d",
                              d, st, initVal(8'h41), W + 2);
      end
      dmacIdle(2);
   endtask

   task automatic test_random();
      int st, c, n;
      logic [15:0] a, d, rd, expd;
      accLog.delete(); expQ.delete();
      for (int i = 0; i < 60; i++) begin
         a = 16'($urandom_range(8'h80, 8'hBF));
         if ($urandom_range(0, 9) < 6) begin
            d = 16'($urandom);
            dmacWrite(a, d, st, c);
         end else begin
            expd = goldValid[a[7:0]] ? goldMem[a[7:0]] : initVal(a[7:0]);
            dmacRead(a, rd, st, c);
            checks++;
            if (rd !== expd) begin
               failures++; $display("[TB] FAIL random_read: adr=%h got %h, expected %h", a, rd, expd);
            end
         end
         if ($urandom_range(0, 3) == 0) dmacIdle(1);
      end
      dmacIdle(60);
      checks++;
      if (accLog.size() !== expQ.size()) begin
         failures++; $display("[TB] FAIL random_count: got %0d accesses, expected %0d", accLog.size(), expQ.size());
      end
      n = (accLog.size() < expQ.size()) ? accLog.size() : expQ.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (accLog[i].wr !== expQ[i].wr || accLog[i].adr !== expQ[i].adr || accLog[i].len !== ACC_LEN ||
             (expQ[i].wr && accLog[i].data !== expQ[i].data)) begin
            failures++;
            $display("[TB] FAIL random_access%0d: got wr=%b adr=%h data=%h len=%0d, expected %b %h %h %0d",
                     i, accLog[i].wr, accLog[i].adr, accLog[i].data, accLog[i].len,
                     expQ[i].wr, expQ[i].adr, expQ[i].data, ACC_LEN);
         end
      end
   endtask

   initial begin
      bus.sp_en = 1'b0; bus.wr_rd_sp = 1'b0; bus.SPA = '0; bus.SPD_OUT = '0;
      $display("[TB] starting sp_wait_bridge bench");
      test_reset();
      test_single_write();
      test_burst();
      test_read();
      test_raw();
      test_reset_mid_read();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
